// File: rtl/xbus_responder.sv
// xbus_responder: MCX XBus far-end responder with saturating TX/RX FIFOs; XBUS_SLX_EN adds bus_wake.
module xbus_responder #(
  parameter int DATA_W  = 11,
  parameter int DEPTH   = 4,
  parameter int MAX_MAG = 999
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     bus_req,
  input  logic                     bus_wr,
  input  logic signed [DATA_W-1:0] bus_wdata,
  output logic                     bus_ack,
  output logic signed [DATA_W-1:0] bus_rdata,
  output logic                     dev_out_valid,
  output logic signed [DATA_W-1:0] dev_out_data,
  input  logic                     dev_out_ready,
  input  logic                     dev_in_valid,
  input  logic signed [DATA_W-1:0] dev_in_data,
  output logic                     dev_in_ready
`ifdef XBUS_SLX_EN
  ,
  output logic                     bus_wake
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic signed [DATA_W-1:0] MAXV = DATA_W'(MAX_MAG);
  localparam logic signed [DATA_W-1:0] MINV = -MAXV;
  typedef enum logic [1:0] {IDLE, WAIT_WR, WAIT_RD, ACK} state_t;
  state_t state;
  logic signed [DATA_W-1:0] tx_mem [DEPTH];
  logic signed [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_cnt, rx_cnt, tx_cnt_nxt, rx_cnt_nxt;
  logic tx_push, tx_pop, rx_push, rx_pop;
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W-1:0] v);
    return v > MAXV ? MAXV : v < MINV ? MINV : v;
  endfunction
  // Full/empty decisions use registered counts only, so a same-cycle pop never unblocks a push.
  always_comb begin
    tx_push    = tx_cnt != FULL && ((state == IDLE && bus_req && bus_wr) || state == WAIT_WR);
    rx_pop     = rx_cnt != '0 && ((state == IDLE && bus_req && !bus_wr) || state == WAIT_RD);
    tx_pop     = dev_out_valid && dev_out_ready;
    rx_push    = dev_in_valid && dev_in_ready;
    tx_cnt_nxt = tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    rx_cnt_nxt = rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
  end
  assign dev_out_valid = tx_cnt != '0;
  assign dev_out_data  = dev_out_valid ? tx_mem[tx_rp] : '0;
  assign dev_in_ready  = rx_cnt != FULL;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
`ifdef XBUS_SLX_EN
      bus_wake  <= 1'b0;
`endif
    end else begin
      bus_ack <= tx_push || rx_pop;
      state   <= (tx_push || rx_pop) ? ACK :
                 (state == IDLE && bus_req) ? (bus_wr ? WAIT_WR : WAIT_RD) :
                 (state == ACK) ? IDLE : state;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) begin
        rx_rp     <= rx_rp + 1'b1;
        bus_rdata <= rx_mem[rx_rp];
      end
      tx_cnt <= tx_cnt_nxt;
      rx_cnt <= rx_cnt_nxt;
`ifdef XBUS_SLX_EN
      bus_wake <= rx_cnt_nxt != '0;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= sat(bus_wdata);
    if (rx_push) rx_mem[rx_wp] <= sat(dev_in_data);
  end
endmodule

// File: tb/tb_xbus_responder.sv
// tb_xbus_responder: directed vector and sequence bench for xbus_responder.
module tb_xbus_responder;
  logic clk = 0, nrst = 0;
  logic bus_req = 0, bus_wr = 0, bus_ack;
  logic signed [10:0] bus_wdata = 0, bus_rdata, dev_out_data, dev_in_data = 0;
  logic dev_out_valid, dev_out_ready = 0, dev_in_valid = 0, dev_in_ready;
`ifdef XBUS_SLX_EN
  logic bus_wake;
`endif
  int tests = 0, fails = 0;
  xbus_responder dut (
    .clk(clk), .nrst(nrst), .bus_req(bus_req), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .dev_out_valid(dev_out_valid),
    .dev_out_data(dev_out_data), .dev_out_ready(dev_out_ready), .dev_in_valid(dev_in_valid),
    .dev_in_data(dev_in_data), .dev_in_ready(dev_in_ready)
`ifdef XBUS_SLX_EN
    , .bus_wake(bus_wake)
`endif
  );
  always #5 clk = ~clk;
  logic prev_req = 0, prev_wr = 0, prev_nrst = 0;
  logic signed [10:0] prev_wdata = 0;
  // wr/wdata must hold while a request stays asserted across edges
  always @(posedge clk) begin
    if (nrst && prev_nrst && bus_req && prev_req)
      assert (bus_wr == prev_wr && bus_wdata == prev_wdata)
      else begin
        fails++;
        $display("FAIL wr_stable: wr %0b->%0b wdata %0d->%0d must be held", prev_wr, bus_wr, prev_wdata, bus_wdata);
      end
    prev_req <= bus_req; prev_wr <= bus_wr; prev_wdata <= bus_wdata; prev_nrst <= nrst;
  end
  typedef struct { logic rd; logic signed [10:0] val; logic signed [10:0] exp; } vec_t;
  vec_t vt[12];
  function automatic vec_t mk(input logic rd, input int v, input int e);
    vec_t r;
    r.rd = rd; r.val = 11'(v); r.exp = 11'(e);
    return r;
  endfunction
  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_write(input logic signed [10:0] v, output int lat);
    @(negedge clk);
    bus_req = 1; bus_wr = 1; bus_wdata = v; lat = 0;
    do begin @(negedge clk); lat++; end while (!bus_ack && lat < 30);
    if (!bus_ack) check("write_timeout", 0, 1);
    bus_req = 0;
  endtask
  task automatic do_read(output logic signed [10:0] v, output int lat);
    @(negedge clk);
    bus_req = 1; bus_wr = 0; lat = 0;
    do begin @(negedge clk); lat++; end while (!bus_ack && lat < 30);
    if (!bus_ack) check("read_timeout", 0, 1);
    v = bus_rdata;
    bus_req = 0;
  endtask
  task automatic dev_push(input logic signed [10:0] v);
    @(negedge clk);
    dev_in_valid = 1; dev_in_data = v;
    @(negedge clk);
    dev_in_valid = 0;
  endtask
  task automatic tx_pop();
    @(negedge clk);
    dev_out_ready = 1;
    @(negedge clk);
    dev_out_ready = 0;
  endtask
  initial begin
    int lat, acks;
    logic signed [10:0] rv;
    vt[0]  = mk(0, 42, 42);      vt[1]  = mk(0, 1023, 999);
    vt[2]  = mk(0, -1024, -999); vt[3]  = mk(0, 999, 999);
    vt[4]  = mk(0, -1000, -999); vt[5]  = mk(0, 0, 0);
    vt[6]  = mk(1, -7, -7);      vt[7]  = mk(1, -1024, -999);
    vt[8]  = mk(1, 1000, 999);   vt[9]  = mk(1, -999, -999);
    vt[10] = mk(1, 5, 5);        vt[11] = mk(0, -1, -1);
    repeat (2) @(negedge clk);
    check("rst_ack", bus_ack, 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_out_valid", dev_out_valid, 0);
    check("rst_out_data", dev_out_data, 0);
    check("rst_in_ready", dev_in_ready, 1);
`ifdef XBUS_SLX_EN
    check("rst_wake", bus_wake, 0);
`endif
    nrst = 1;
    do_write(42, lat);
    check("wr_latency", lat, 1);
    check("wr_out_valid", dev_out_valid, 1);
    check("wr_out_data", dev_out_data, 42);
    @(negedge clk);
    check("wr_ack_one_cycle", bus_ack, 0);
    tx_pop();
    check("wr_popped", dev_out_valid, 0);
    for (int i = 0; i < 12; i++) begin
      if (vt[i].rd) begin
        dev_push(vt[i].val);
        do_read(rv, lat);
        check($sformatf("vec%0d_rd_lat", i), lat, 1);
        check($sformatf("vec%0d_rdata", i), rv, vt[i].exp);
      end else begin
        do_write(vt[i].val, lat);
        check($sformatf("vec%0d_wr_lat", i), lat, 1);
        check($sformatf("vec%0d_out_data", i), dev_out_data, vt[i].exp);
        tx_pop();
      end
    end
    // blocking read released by a device push
    @(negedge clk);
    bus_req = 1; bus_wr = 0; acks = 0;
    repeat (5) begin @(negedge clk); acks += int'(bus_ack); end
    check("blk_rd_no_ack", acks, 0);
    dev_in_valid = 1; dev_in_data = -7;
    @(negedge clk);
    dev_in_valid = 0;
    check("blk_rd_m1_ack", bus_ack, 0);
    @(negedge clk);
    check("blk_rd_m2_ack", bus_ack, 1);
    check("blk_rd_rdata", bus_rdata, -7);
    bus_req = 0;
    @(negedge clk);
    check("blk_rd_ack_drop", bus_ack, 0);
    check("blk_rd_rdata_hold", bus_rdata, -7);
    // TX full: 4 writes complete, 5th stalls until a pop, then completes two cycles later
    for (int i = 1; i <= 4; i++) begin
      do_write(11'(i), lat);
      check($sformatf("full_wr%0d_lat", i), lat, 1);
    end
    @(negedge clk);
    bus_req = 1; bus_wr = 1; bus_wdata = 5; acks = 0;
    repeat (10) begin @(negedge clk); acks += int'(bus_ack); end
    check("full_stall", acks, 0);
    check("full_head", dev_out_data, 1);
    dev_out_ready = 1;
    @(negedge clk);
    dev_out_ready = 0;
    check("full_k1_ack", bus_ack, 0);
    check("full_k1_head", dev_out_data, 2);
    @(negedge clk);
    check("full_k2_ack", bus_ack, 1);
    bus_req = 0;
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("drain%0d_valid", i), dev_out_valid, 1);
      check($sformatf("drain%0d_data", i), dev_out_data, i);
      tx_pop();
    end
    check("drain_empty", dev_out_valid, 0);
    // simultaneous device push and MCX pop on RX
    dev_push(10);
    @(negedge clk);
    bus_req = 1; bus_wr = 0; dev_in_valid = 1; dev_in_data = 20;
    @(negedge clk);
    dev_in_valid = 0;
    check("simul_ack", bus_ack, 1);
    check("simul_rdata", bus_rdata, 10);
    bus_req = 0;
    do_read(rv, lat);
    check("simul_second", rv, 20);
    check("simul_second_lat", lat, 1);
    // RX full: ready drops, extra offer is refused, order preserved
    do_write(77, lat);
    for (int i = 1; i <= 4; i++) dev_push(11'(i * 100));
    check("rx_full_ready", dev_in_ready, 0);
    dev_push(9);
    for (int i = 1; i <= 4; i++) begin
      do_read(rv, lat);
      check($sformatf("rx_full_rd%0d", i), rv, i * 100);
    end
    check("rx_ready_again", dev_in_ready, 1);
    // RX empty read parks in WAIT_RD, then reset mid-transaction
    @(negedge clk);
    bus_req = 1; bus_wr = 0; acks = 0;
    repeat (3) begin @(negedge clk); acks += int'(bus_ack); end
    check("rx_empty_stall", acks, 0);
    check("pre_rst_out_valid", dev_out_valid, 1);
    nrst = 0; bus_req = 0;
    repeat (2) @(negedge clk);
    check("mid_rst_ack", bus_ack, 0);
    check("mid_rst_rdata", bus_rdata, 0);
    check("mid_rst_in_ready", dev_in_ready, 1);
    check("mid_rst_out_valid", dev_out_valid, 0);
    nrst = 1;
    @(negedge clk);
    check("post_rst_no_ack", bus_ack, 0);
    do_write(-3, lat);
    check("post_rst_idle_lat", lat, 1);
    check("post_rst_data", dev_out_data, -3);
    tx_pop();
`ifdef XBUS_SLX_EN
    check("wake_idle", bus_wake, 0);
    @(negedge clk);
    dev_in_valid = 1; dev_in_data = 3;
    @(negedge clk);
    dev_in_valid = 0;
    check("wake_rise", bus_wake, 1);
    do_read(rv, lat);
    check("wake_rdata", rv, 3);
    @(negedge clk);
    check("wake_fall", bus_wake, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
